// File: rtl/j1_pkg.sv
// j1_pkg: shared types for the J1 Wishbone CPU.
// Holds the instruction-class and ALU-opcode enums, the sequencer state
// enum, the ALU no-op encoding and a small instruction classifier.
package j1_pkg;

  typedef enum logic [2:0] {
    CLS_LIT,
    CLS_JMP,
    CLS_JZ,
    CLS_CALL,
    CLS_ALU
  } insnClass_e;

  typedef enum logic [3:0] {
    ALU_T     = 4'd0,
    ALU_N     = 4'd1,
    ALU_ADD   = 4'd2,
    ALU_AND   = 4'd3,
    ALU_OR    = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_INV   = 4'd6,
    ALU_EQ    = 4'd7,
    ALU_LT    = 4'd8,
    ALU_RSH   = 4'd9,
    ALU_DEC   = 4'd10,
    ALU_R     = 4'd11,
    ALU_LOAD  = 4'd12,
    ALU_LSH   = 4'd13,
    ALU_DEPTH = 4'd14,
    ALU_ULT   = 4'd15
  } aluOp_e;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    MEM
  } cpuState_e;

  // ALU instruction with no side effects; substituted for a failed fetch.
  localparam logic [15:0] NOOP = 16'h6000;

  // Literal when bit 15 is set, otherwise bits 14:13 pick the class.
  function automatic insnClass_e classify(input logic [15:0] insn);
    insnClass_e cls;
    cls = CLS_ALU;
    if (insn[15]) begin
      cls = CLS_LIT;
    end else begin
      case (insn[14:13])
        2'b00:   cls = CLS_JMP;
        2'b01:   cls = CLS_JZ;
        2'b10:   cls = CLS_CALL;
        default: cls = CLS_ALU;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/j1_stack.sv
// j1_stack: register-file LIFO used for both the data and return stacks.
// The pointer moves by a 2-bit two's-complement delta and wraps modulo
// DEPTH; an optional write lands in the slot the pointer moves to.
module j1_stack #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 16,
  parameter int SPW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             move_i,
  input  logic [1:0]       delta_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] top_o,
  output logic [SPW-1:0]   sp_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SPW-1:0]   sp_q;
  logic [SPW-1:0]   sp_d;

  // Sign-extend the delta so 2'b10 / 2'b11 step the pointer backwards.
  always_comb begin
    sp_d = sp_q + SPW'($signed(delta_i));
  end

  // Stack pointer; only moves when the core commits an instruction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sp_q <= '0;
    end else if (move_i) begin
      sp_q <= sp_d;
    end
  end

  // Storage array; not reset, since entries are only read after a push.
  always_ff @(posedge clk_i) begin
    if (move_i && we_i) begin
      mem_q[sp_d] <= wdata_i;
    end
  end

  assign top_o = mem_q[sp_q];
  assign sp_o  = sp_q;

endmodule

// File: rtl/j1_wb_core.sv
// j1_wb_core: J1 16-bit dual-stack Forth CPU with two Wishbone B4 classic
// masters: wbc fetches code, wbd performs loads and stores.
// Optional feature macro J1_WB_ERR_EN: when defined, err ends a bus cycle
// like ack (failed fetch -> NOOP, failed load -> 0, failed store dropped);
// otherwise err is ignored.
module j1_wb_core
  import j1_pkg::*;
#(
  parameter int DSTACK_DEPTH = 32,
  parameter int RSTACK_DEPTH = 32
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  output logic [15:0] wbc_adr_o,
  input  logic [15:0] wbc_dat_i,
  output logic [15:0] wbc_dat_o,
  output logic        wbc_we_o,
  output logic [1:0]  wbc_sel_o,
  output logic        wbc_cyc_o,
  output logic        wbc_stb_o,
  input  logic        wbc_ack_i,
  input  logic        wbc_err_i,
  output logic [15:0] wbd_adr_o,
  input  logic [15:0] wbd_dat_i,
  output logic [15:0] wbd_dat_o,
  output logic        wbd_we_o,
  output logic [1:0]  wbd_sel_o,
  output logic        wbd_cyc_o,
  output logic        wbd_stb_o,
  input  logic        wbd_ack_i,
  input  logic        wbd_err_i
);

  localparam int DSPW = $clog2(DSTACK_DEPTH);
  localparam int RSPW = $clog2(RSTACK_DEPTH);

  cpuState_e   state_q, state_d;
  logic [12:0] pc_q, pc_d;
  logic [15:0] tos_q, tos_d;
  logic [15:0] insn_q, insn_d;
  logic        wbcCyc_q, wbcCyc_d;
  logic [15:0] wbcAdr_q, wbcAdr_d;
  logic        wbdCyc_q, wbdCyc_d;
  logic [15:0] wbdAdr_q, wbdAdr_d;
  logic        wbdWe_q, wbdWe_d;
  logic [15:0] wbdDat_q, wbdDat_d;

  logic [15:0] nos, rTop;
  logic [DSPW-1:0] dsp;
  logic [RSPW-1:0] rsp;

  logic        wbcDone, wbdDone;
  logic [15:0] fetchData, loadData;
  logic        commit, needMem;
  insnClass_e  cls;
  aluOp_e      aluOp;
  logic [15:0] aluOut, tNext, rWdata;
  logic [12:0] pcPlus, pcNext;
  logic [1:0]  dDelta, rDelta;
  logic        dWe, rWe;

`ifdef J1_WB_ERR_EN
  assign wbcDone   = wbcCyc_q && (wbc_ack_i || wbc_err_i);
  assign wbdDone   = wbdCyc_q && (wbd_ack_i || wbd_err_i);
  assign fetchData = wbc_ack_i ? wbc_dat_i : NOOP;
  assign loadData  = wbd_ack_i ? wbd_dat_i : 16'h0000;
`else
  logic unusedErr;
  assign unusedErr = wbc_err_i ^ wbd_err_i;
  assign wbcDone   = wbcCyc_q && wbc_ack_i;
  assign wbdDone   = wbdCyc_q && wbd_ack_i;
  assign fetchData = wbc_dat_i;
  assign loadData  = wbd_dat_i;
`endif

  // Only R[13:1] is meaningful as a return address.
  logic [2:0] unusedR;
  assign unusedR = {rTop[15:14], rTop[0]};

  assign cls     = classify(insn_q);
  assign aluOp   = aluOp_e'(insn_q[11:8]);
  assign needMem = (cls == CLS_ALU) && ((aluOp == ALU_LOAD) || insn_q[5]);
  assign pcPlus  = pc_q + 13'd1;

  // ALU result; a load with the store bit set is write-only and yields 0.
  always_comb begin
    aluOut = tos_q;
    case (aluOp)
      ALU_T:     aluOut = tos_q;
      ALU_N:     aluOut = nos;
      ALU_ADD:   aluOut = tos_q + nos;
      ALU_AND:   aluOut = tos_q & nos;
      ALU_OR:    aluOut = tos_q | nos;
      ALU_XOR:   aluOut = tos_q ^ nos;
      ALU_INV:   aluOut = ~tos_q;
      ALU_EQ:    aluOut = (nos == tos_q) ? 16'hFFFF : 16'h0000;
      ALU_LT:    aluOut = ($signed(nos) < $signed(tos_q)) ? 16'hFFFF : 16'h0000;
      ALU_RSH:   aluOut = nos >> tos_q[3:0];
      ALU_DEC:   aluOut = tos_q - 16'd1;
      ALU_R:     aluOut = rTop;
      ALU_LOAD:  aluOut = insn_q[5] ? 16'h0000 : loadData;
      ALU_LSH:   aluOut = nos << tos_q[3:0];
      ALU_DEPTH: aluOut = 16'({rsp, dsp});
      ALU_ULT:   aluOut = (nos < tos_q) ? 16'hFFFF : 16'h0000;
      default:   aluOut = tos_q;
    endcase
  end

  // Instruction decode: next T, next pc and both stack effects.
  always_comb begin
    tNext  = tos_q;
    pcNext = pcPlus;
    dDelta = 2'b00;
    dWe    = 1'b0;
    rDelta = 2'b00;
    rWe    = 1'b0;
    rWdata = tos_q;
    case (cls)
      CLS_LIT: begin
        tNext  = {1'b0, insn_q[14:0]};
        dDelta = 2'b01;
        dWe    = 1'b1;
      end
      CLS_JMP: pcNext = insn_q[12:0];
      CLS_JZ: begin
        pcNext = (tos_q == 16'h0000) ? insn_q[12:0] : pcPlus;
        tNext  = nos;
        dDelta = 2'b11;
      end
      CLS_CALL: begin
        pcNext = insn_q[12:0];
        rDelta = 2'b01;
        rWe    = 1'b1;
        rWdata = {2'b00, pcPlus, 1'b0};
      end
      CLS_ALU: begin
        tNext  = aluOut;
        pcNext = insn_q[12] ? rTop[13:1] : pcPlus;
        dDelta = insn_q[1:0];
        dWe    = insn_q[7];
        rDelta = insn_q[3:2];
        rWe    = insn_q[6];
      end
      default: ;
    endcase
  end

  // Sequencer: FETCH -> EXEC -> (MEM) -> FETCH, plus bus handshakes.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tos_d    = tos_q;
    insn_d   = insn_q;
    wbcCyc_d = wbcCyc_q;
    wbcAdr_d = wbcAdr_q;
    wbdCyc_d = wbdCyc_q;
    wbdAdr_d = wbdAdr_q;
    wbdWe_d  = wbdWe_q;
    wbdDat_d = wbdDat_q;
    commit   = 1'b0;
    case (state_q)
      FETCH: begin
        if (!wbcCyc_q) begin
          wbcCyc_d = 1'b1;
          wbcAdr_d = {2'b00, pc_q, 1'b0};
        end else if (wbcDone) begin
          insn_d   = fetchData;
          wbcCyc_d = 1'b0;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (needMem) begin
          state_d  = MEM;
          wbdCyc_d = 1'b1;
          wbdAdr_d = tos_q;
          wbdWe_d  = insn_q[5];
          wbdDat_d = nos;
        end else begin
          commit = 1'b1;
        end
      end
      MEM: begin
        if (wbdDone) begin
          commit   = 1'b1;
          wbdCyc_d = 1'b0;
          wbdWe_d  = 1'b0;
        end
      end
      default: state_d = FETCH;
    endcase
    if (commit) begin
      pc_d     = pcNext;
      tos_d    = tNext;
      state_d  = FETCH;
      wbcCyc_d = 1'b1;
      wbcAdr_d = {2'b00, pcNext, 1'b0};
    end
  end

  // Architectural and bus registers; reset drops both bus cycles at once.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q  <= FETCH;
      pc_q     <= '0;
      tos_q    <= '0;
      insn_q   <= NOOP;
      wbcCyc_q <= 1'b0;
      wbcAdr_q <= '0;
      wbdCyc_q <= 1'b0;
      wbdAdr_q <= '0;
      wbdWe_q  <= 1'b0;
      wbdDat_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      tos_q    <= tos_d;
      insn_q   <= insn_d;
      wbcCyc_q <= wbcCyc_d;
      wbcAdr_q <= wbcAdr_d;
      wbdCyc_q <= wbdCyc_d;
      wbdAdr_q <= wbdAdr_d;
      wbdWe_q  <= wbdWe_d;
      wbdDat_q <= wbdDat_d;
    end
  end

  j1_stack #(.DEPTH(DSTACK_DEPTH), .WIDTH(16)) uDstack (
    .clk_i   (sys_clk_i),
    .rst_i   (sys_rst_i),
    .move_i  (commit),
    .delta_i (dDelta),
    .we_i    (dWe),
    .wdata_i (tos_q),
    .top_o   (nos),
    .sp_o    (dsp)
  );

  j1_stack #(.DEPTH(RSTACK_DEPTH), .WIDTH(16)) uRstack (
    .clk_i   (sys_clk_i),
    .rst_i   (sys_rst_i),
    .move_i  (commit),
    .delta_i (rDelta),
    .we_i    (rWe),
    .wdata_i (rWdata),
    .top_o   (rTop),
    .sp_o    (rsp)
  );

  assign wbc_adr_o = wbcAdr_q;
  assign wbc_dat_o = 16'h0000;
  assign wbc_we_o  = 1'b0;
  assign wbc_sel_o = 2'b11;
  assign wbc_cyc_o = wbcCyc_q;
  assign wbc_stb_o = wbcCyc_q;
  assign wbd_adr_o = wbdAdr_q;
  assign wbd_dat_o = wbdDat_q;
  assign wbd_we_o  = wbdWe_q;
  assign wbd_sel_o = 2'b11;
  assign wbd_cyc_o = wbdCyc_q;
  assign wbd_stb_o = wbdCyc_q;

endmodule

// File: tb/tb_j1_wb_core.sv
// tb_j1_wb_core: directed test of j1_wb_core with a ROM slave on wbc and a
// RAM slave on wbd, both with a programmable number of wait states.
module tb_j1_wb_core;

  logic        sysClk = 1'b0;
  logic        sysRst = 1'b1;
  logic [15:0] wbcAdr, wbcDatIn, wbcDatOut;
  logic        wbcWe, wbcCyc, wbcStb, wbcAck;
  logic [1:0]  wbcSel;
  logic [15:0] wbdAdr, wbdDatIn, wbdDatOut;
  logic        wbdWe, wbdCyc, wbdStb, wbdAck;
  logic [1:0]  wbdSel;

  int          waitStates = 0;
  int          wbcCnt, wbdCnt;
  logic [15:0] romMem [0:63];
  logic [15:0] ramMem [0:1023];

  int          vectorCount = 0;
  int          missCount = 0;
  int          cycleCount = 0;

  int          fetchCount, writeCount, stabViol;
  logic [15:0] fetchLog [0:63];
  int          fetchCyc [0:63];
  logic [15:0] writeAdrLog [0:7];
  logic [15:0] writeDatLog [0:7];
  logic        prevCValid, prevDValid;
  logic [15:0] prevCAdr, prevDAdr, prevDDat;

  j1_wb_core dut (
    .sys_clk_i (sysClk),
    .sys_rst_i (sysRst),
    .wbc_adr_o (wbcAdr),
    .wbc_dat_i (wbcDatIn),
    .wbc_dat_o (wbcDatOut),
    .wbc_we_o  (wbcWe),
    .wbc_sel_o (wbcSel),
    .wbc_cyc_o (wbcCyc),
    .wbc_stb_o (wbcStb),
    .wbc_ack_i (wbcAck),
    .wbc_err_i (1'b0),
    .wbd_adr_o (wbdAdr),
    .wbd_dat_i (wbdDatIn),
    .wbd_dat_o (wbdDatOut),
    .wbd_we_o  (wbdWe),
    .wbd_sel_o (wbdSel),
    .wbd_cyc_o (wbdCyc),
    .wbd_stb_o (wbdStb),
    .wbd_ack_i (wbdAck),
    .wbd_err_i (1'b0)
  );

  always #5 sysClk = ~sysClk;

  // Slaves acknowledge combinationally once the strobe has been held for
  // waitStates cycles, so zero wait states gives a same-cycle ack.
  assign wbcAck   = wbcCyc && wbcStb && (wbcCnt == waitStates);
  assign wbdAck   = wbdCyc && wbdStb && (wbdCnt == waitStates);
  assign wbcDatIn = romMem[wbcAdr[6:1]];
  assign wbdDatIn = ramMem[wbdAdr[9:0]];

  // Wait-state counters restart whenever a strobe ends.
  always @(posedge sysClk or posedge sysRst) begin
    if (sysRst) begin
      wbcCnt <= 0;
      wbdCnt <= 0;
    end else begin
      wbcCnt <= (wbcCyc && wbcStb && !wbcAck) ? wbcCnt + 1 : 0;
      wbdCnt <= (wbdCyc && wbdStb && !wbdAck) ? wbdCnt + 1 : 0;
    end
  end

  always @(posedge sysClk) cycleCount = cycleCount + 1;

  // Bus monitor: logs fetches and stores, and counts any change of a
  // strobed cycle's address/data before it has been acknowledged.
  always @(negedge sysClk) begin
    if (sysRst) begin
      fetchCount = 0;
      writeCount = 0;
      stabViol   = 0;
      prevCValid = 1'b0;
      prevDValid = 1'b0;
      for (int i = 0; i < 64; i++) begin
        fetchLog[i] = 16'hDEAD;
        fetchCyc[i] = 0;
      end
      for (int i = 0; i < 8; i++) begin
        writeAdrLog[i] = 16'hDEAD;
        writeDatLog[i] = 16'hDEAD;
      end
    end else begin
      if (wbcCyc && wbcAck && fetchCount < 64) begin
        fetchLog[fetchCount] = wbcAdr;
        fetchCyc[fetchCount] = cycleCount;
        fetchCount = fetchCount + 1;
      end
      if (wbdCyc && wbdAck && wbdWe) begin
        if (writeCount < 8) begin
          writeAdrLog[writeCount] = wbdAdr;
          writeDatLog[writeCount] = wbdDatOut;
        end
        writeCount = writeCount + 1;
      end
      if (prevCValid && !(wbcCyc && wbcStb && wbcAdr == prevCAdr)) stabViol = stabViol + 1;
      if (prevDValid && !(wbdCyc && wbdStb && wbdAdr == prevDAdr && wbdDatOut == prevDDat))
        stabViol = stabViol + 1;
      prevCValid = wbcCyc && !wbcAck;
      prevCAdr   = wbcAdr;
      prevDValid = wbdCyc && !wbdAck;
      prevDAdr   = wbdAdr;
      prevDDat   = wbdDatOut;
    end
  end

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectorCount = vectorCount + 1;
    if (got !== exp) begin
      missCount = missCount + 1;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic clearRom();
    for (int i = 0; i < 64; i++) romMem[i] = 16'h0000;
  endtask

  // Reset for two cycles with the given wait states, then free-run.
  task automatic applyStimulus(input int waitN, input int cycles);
    sysRst = 1'b1;
    waitStates = waitN;
    repeat (2) @(negedge sysClk);
    sysRst = 1'b0;
    repeat (cycles) @(negedge sysClk);
  endtask

  int  bound;
  logic sawCyc;
  logic [15:0] ctrlSeq [0:6];

  initial begin
    for (int i = 0; i < 1024; i++) ramMem[i] = 16'h0000;
    ramMem[10'h100] = 16'h1234;

    // Reset state, sampled while reset is still held.
    clearRom();
    sysRst = 1'b1;
    repeat (2) @(negedge sysClk);
    checkOutput("rst_wbc_cyc", {15'd0, wbcCyc}, 16'd0);
    checkOutput("rst_wbd_cyc", {15'd0, wbdCyc}, 16'd0);
    checkOutput("rst_wbc_adr", wbcAdr, 16'h0000);
    checkOutput("rst_wbd_we",  {15'd0, wbdWe}, 16'd0);
    checkOutput("rst_sel",     {12'd0, wbcSel, wbdSel}, 16'h000F);
    checkOutput("rst_wbd_dat", wbdDatOut, 16'h0000);

    // 7 + 3 stored at 0x0100, zero wait states.
    clearRom();
    romMem[0] = 16'h8007; romMem[1] = 16'h8003; romMem[2] = 16'h6203;
    romMem[3] = 16'h8100; romMem[4] = 16'h6023; romMem[5] = 16'h0005;
    applyStimulus(0, 80);
    checkOutput("add_fetch0", fetchLog[0], 16'h0000);
    checkOutput("add_fetch1", fetchLog[1], 16'h0002);
    checkOutput("add_gap",    16'(fetchCyc[1] - fetchCyc[0]), 16'd2);
    checkOutput("add_wcount", 16'(writeCount), 16'd1);
    checkOutput("add_wadr",   writeAdrLog[0], 16'h0100);
    checkOutput("add_wdat",   writeDatLog[0], 16'h000A);

    // Load from 0x0100 then store to 0x0200.
    clearRom();
    romMem[0] = 16'h8100; romMem[1] = 16'h6C00; romMem[2] = 16'h8200;
    romMem[3] = 16'h6023; romMem[4] = 16'h0004;
    applyStimulus(0, 80);
    checkOutput("ld_wcount", 16'(writeCount), 16'd1);
    checkOutput("ld_wadr",   writeAdrLog[0], 16'h0200);
    checkOutput("ld_wdat",   writeDatLog[0], 16'h1234);

    // 12 << 2 stored at 0x0300.
    clearRom();
    romMem[0] = 16'h800C; romMem[1] = 16'h8002; romMem[2] = 16'h6D03;
    romMem[3] = 16'h8300; romMem[4] = 16'h6023; romMem[5] = 16'h0005;
    applyStimulus(0, 80);
    checkOutput("lsh_wadr", writeAdrLog[0], 16'h0300);
    checkOutput("lsh_wdat", writeDatLog[0], 16'h0030);

    // Call/return, then 0branch taken at T=0 and not taken at T=1.
    clearRom();
    romMem[0] = 16'h4005; romMem[1] = 16'h8000; romMem[2] = 16'h2006;
    romMem[5] = 16'h700C; romMem[6] = 16'h8001; romMem[7] = 16'h2009;
    romMem[8] = 16'h0008;
    ctrlSeq[0] = 16'h0000; ctrlSeq[1] = 16'h000A; ctrlSeq[2] = 16'h0002;
    ctrlSeq[3] = 16'h0004; ctrlSeq[4] = 16'h000C; ctrlSeq[5] = 16'h000E;
    ctrlSeq[6] = 16'h0010;
    applyStimulus(0, 60);
    for (int i = 0; i < 7; i++) checkOutput($sformatf("ctl_fetch%0d", i), fetchLog[i], ctrlSeq[i]);
    checkOutput("ctl_wcount", 16'(writeCount), 16'd0);

    // Addition program again with three wait states on both buses.
    clearRom();
    romMem[0] = 16'h8007; romMem[1] = 16'h8003; romMem[2] = 16'h6203;
    romMem[3] = 16'h8100; romMem[4] = 16'h6023; romMem[5] = 16'h0005;
    applyStimulus(3, 150);
    checkOutput("ws_fetch1", fetchLog[1], 16'h0002);
    checkOutput("ws_gap",    16'(fetchCyc[1] - fetchCyc[0]), 16'd5);
    checkOutput("ws_wcount", 16'(writeCount), 16'd1);
    checkOutput("ws_wadr",   writeAdrLog[0], 16'h0100);
    checkOutput("ws_wdat",   writeDatLog[0], 16'h000A);
    checkOutput("ws_stable", 16'(stabViol), 16'd0);

    // Reset asserted in the middle of a stalled fetch drops cyc/stb at once.
    sysRst = 1'b1;
    repeat (2) @(negedge sysClk);
    sysRst = 1'b0;
    sawCyc = 1'b0;
    bound = 0;
    while (!sawCyc && bound < 10) begin
      @(negedge sysClk);
      sawCyc = wbcCyc;
      bound = bound + 1;
    end
    checkOutput("mid_saw_cyc", {15'd0, sawCyc}, 16'd1);
    #1 sysRst = 1'b1;
    #1;
    checkOutput("mid_rst_cyc", {14'd0, wbcCyc, wbcStb}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
